// File: rtl/brake_bus_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Package  : brake_bus_pkg
// Desc     : Shared types and constants for the brake register-bus arbiter.
// Revision : 1.0 - initial release
//==============================================================================
package brake_bus_pkg;

    localparam int BUS_AW = 8;
    localparam int BUS_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_OWN   = 3'b010,
        ST_GUARD = 3'b100
    } state_e;

    localparam logic c_csn_idle = 1'b1;
    localparam logic c_we_idle  = 1'b0;
    localparam logic c_re_idle  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/brake_bus_arbiter_if.sv
`default_nettype none
//==============================================================================
// Interface: brake_bus_arbiter_if
// Desc     : Requester-side and controller-side signals of the brake bus arbiter.
// Revision : 1.0 - initial release
//==============================================================================
interface brake_bus_arbiter_if
    import brake_bus_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic                      ms_pulse;
    logic [NUM_REQ-1:0]        req_bus_on;
    logic [NUM_REQ-1:0]        req_csn;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_re;
    logic [BUS_AW*NUM_REQ-1:0] req_addr;
    logic [BUS_DW*NUM_REQ-1:0] req_din;
    logic [NUM_REQ-1:0]        req_grant;
    logic [BUS_DW-1:0]         req_dout;
    logic [NUM_REQ-1:0]        req_revoke;
    logic                      bus_csn;
    logic                      bus_we;
    logic                      bus_re;
    logic [BUS_AW-1:0]         bus_addr;
    logic [BUS_DW-1:0]         bus_din;
    logic [BUS_DW-1:0]         bus_dout;
    logic [2:0]                owner_id;
    logic                      busy;

    modport master (
        input  ms_pulse, req_bus_on, req_csn, req_we, req_re, req_addr, req_din, bus_dout,
        output req_grant, req_dout, req_revoke, bus_csn, bus_we, bus_re, bus_addr, bus_din,
               owner_id, busy
    );

    modport slave (
        output ms_pulse, req_bus_on, req_csn, req_we, req_re, req_addr, req_din, bus_dout,
        input  req_grant, req_dout, req_revoke, bus_csn, bus_we, bus_re, bus_addr, bus_din,
               owner_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/brake_bus_rr_pick.sv
`default_nettype none
//==============================================================================
// Module   : brake_bus_rr_pick
// Desc     : Winner select: requester 0 absolute, 1..NUM_REQ-1 round-robin.
// Revision : 1.0 - initial release
//==============================================================================
module brake_bus_rr_pick #(
    parameter int NUM_REQ = 3
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [2:0]         i_ptr,
    output logic      [2:0]         o_win,
    output logic                    o_vld
);
    logic [NUM_REQ-1:0] w_upper;

    always_comb begin
        w_upper = '0;
        o_win   = 3'd0;
        o_vld   = |i_req;
        for (int i = 1; i < NUM_REQ; i++) begin
            w_upper[i] = i_req[i] && (i >= int'(i_ptr));
        end
        // Downward scan leaves the lowest set index; fall back to the wrapped range.
        if (|w_upper) begin
            for (int i = NUM_REQ - 1; i >= 1; i--) begin
                if (w_upper[i]) o_win = 3'(i);
            end
        end else begin
            for (int i = NUM_REQ - 1; i >= 1; i--) begin
                if (i_req[i]) o_win = 3'(i);
            end
        end
        if (i_req[0]) o_win = 3'd0;
    end
endmodule
`default_nettype wire

// File: rtl/brake_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : brake_bus_arbiter
// Desc     : Single-owner arbiter for the brake CAN-controller register bus.
// Optional : BRAKE_BUS_HOLD_TIMEOUT_EN adds the HOLD_MS ownership revoke.
// Revision : 1.0 - initial release
//==============================================================================
module brake_bus_arbiter
    import brake_bus_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int GUARD_CYCLES = 4,
    parameter int HOLD_MS      = 50
) (
    input  wire logic          clk,
    input  wire logic          rst,
    brake_bus_arbiter_if.master bus_if
);
    localparam logic [3:0] c_guard_last = (GUARD_CYCLES == 0) ? 4'd0 : 4'(GUARD_CYCLES - 1);
    localparam logic [2:0] c_last_req   = 3'(NUM_REQ - 1);

    state_e              r_state, w_next;
    logic [2:0]          r_owner, r_ptr, w_win;
    logic                w_win_vld, w_leave, w_timeout;
    logic [NUM_REQ-1:0]  r_grant, w_eligible;
    logic [3:0]          r_guard_cnt;
    logic                r_csn, r_we, r_re;
    logic [BUS_AW-1:0]   r_addr, w_own_addr;
    logic [BUS_DW-1:0]   r_din, r_dout, w_own_din;
    logic                w_own_on, w_own_csn, w_own_we, w_own_re;

    always_comb begin
        w_own_on   = 1'b0;
        w_own_csn  = c_csn_idle;
        w_own_we   = c_we_idle;
        w_own_re   = c_re_idle;
        w_own_addr = '0;
        w_own_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == 3'(i)) begin
                w_own_on   = bus_if.req_bus_on[i];
                w_own_csn  = bus_if.req_csn[i];
                w_own_we   = bus_if.req_we[i];
                w_own_re   = bus_if.req_re[i];
                w_own_addr = bus_if.req_addr[BUS_AW*i +: BUS_AW];
                w_own_din  = bus_if.req_din[BUS_DW*i +: BUS_DW];
            end
        end
    end

`ifdef BRAKE_BUS_HOLD_TIMEOUT_EN
    logic [7:0]         r_ms_cnt;
    logic [NUM_REQ-1:0] r_lockout, r_revoke;
    logic               w_revoke_now;

    assign w_timeout    = (r_state == ST_OWN) && (r_ms_cnt >= 8'(HOLD_MS));
    assign w_revoke_now = w_timeout && w_own_on;
    assign w_eligible   = bus_if.req_bus_on & ~r_lockout;
    assign bus_if.req_revoke = r_revoke;

    // Lockout survives until the revoked requester is seen with bus_on low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ms_cnt  <= 8'd0;
            r_lockout <= '0;
            r_revoke  <= '0;
        end else begin
            if (r_state != ST_OWN) r_ms_cnt <= 8'd0;
            else if (bus_if.ms_pulse && r_ms_cnt != 8'hFF) r_ms_cnt <= r_ms_cnt + 8'd1;
            r_revoke  <= w_revoke_now ? r_grant : '0;
            r_lockout <= (r_lockout | (w_revoke_now ? r_grant : '0)) & bus_if.req_bus_on;
        end
    end
`else
    logic w_unused_ms;
    assign w_unused_ms       = bus_if.ms_pulse;
    assign w_timeout         = 1'b0;
    assign w_eligible        = bus_if.req_bus_on;
    assign bus_if.req_revoke = '0;
`endif

    brake_bus_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req (w_eligible),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_vld (w_win_vld)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_win_vld) w_next = ST_OWN;
            ST_OWN:   if (!w_own_on || w_timeout) w_next = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
            ST_GUARD: if (r_guard_cnt == c_guard_last) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign w_leave = (r_state == ST_OWN) && (w_next != ST_OWN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 3'd0;
            r_ptr       <= 3'd1;
            r_grant     <= '0;
            r_guard_cnt <= 4'd0;
            r_csn       <= c_csn_idle;
            r_we        <= c_we_idle;
            r_re        <= c_re_idle;
            r_addr      <= '0;
            r_din       <= '0;
            r_dout      <= '0;
        end else begin
            r_state     <= w_next;
            r_dout      <= bus_if.bus_dout;
            r_guard_cnt <= (r_state == ST_GUARD) ? r_guard_cnt + 4'd1 : 4'd0;
            if (r_state == ST_IDLE && w_win_vld) begin
                r_owner <= w_win;
                r_grant <= NUM_REQ'(1) << w_win;
            end
            if (w_leave) begin
                r_grant <= '0;
                if (r_owner != 3'd0) r_ptr <= (r_owner == c_last_req) ? 3'd1 : r_owner + 3'd1;
            end
            // Strobes only pass while ownership continues; addr/din hold otherwise.
            if (r_state == ST_OWN && w_next == ST_OWN) begin
                r_csn  <= w_own_csn;
                r_we   <= w_own_we;
                r_re   <= w_own_re;
                r_addr <= w_own_addr;
                r_din  <= w_own_din;
            end else begin
                r_csn  <= c_csn_idle;
                r_we   <= c_we_idle;
                r_re   <= c_re_idle;
            end
        end
    end

    assign bus_if.req_grant = r_grant;
    assign bus_if.req_dout  = r_dout;
    assign bus_if.bus_csn   = r_csn;
    assign bus_if.bus_we    = r_we;
    assign bus_if.bus_re    = r_re;
    assign bus_if.bus_addr  = r_addr;
    assign bus_if.bus_din   = r_din;
    assign bus_if.owner_id  = r_owner;
    assign bus_if.busy      = (r_state != ST_IDLE);
endmodule
`default_nettype wire
